mem_access: RTL

//   Memory stage directly downstream of the execute stage. Consumes the execute-stage write-back

---
 rtl/mem_access.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory stage: runs req/ack bus transactions for loads and stores,
// passes other ops through, and registers the write-back triple.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  memOp_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] storeData_i,
  input  logic        writeReg_i,
  input  logic [4:0]  writeAddr_i,
  input  logic [31:0] writeData_i,
  output logic        memReq_o,
  output logic        memWe_o,
  output logic [31:0] memAddr_o,
  output logic [3:0]  memSel_o,
  output logic [31:0] memWdata_o,
  input  logic [31:0] memRdata_i,
  input  logic        memAck_i,
  output logic        stallReq_o,
  output logic        writeReg_o,
  output logic [4:0]  writeAddr_o,
  output logic [31:0] writeData_o,
  output logic        excAddr_o,
  output logic        busErr_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  state_t      state_n;
  logic [7:0]  cnt;
  logic [3:0]  op_q;
  logic [1:0]  lo_q;
  logic        wreg_q;
  logic [4:0]  waddr_q;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        is_mem;
  logic        is_st;
  logic        misal;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] ld_c;
  logic        ld_q;
  logic        tmo;

  assign memReq_o   = (state == WAIT);
  assign stallReq_o = (state == WAIT);
  assign ld_q       = (op_q >= OP_LB) && (op_q <= OP_LW);
  assign tmo        = (cnt == TMAX);

  always_comb begin
    is_byte = (memOp_i == OP_LB) || (memOp_i == OP_LBU) ||
              (memOp_i == OP_SB);
    is_half = (memOp_i == OP_LH) || (memOp_i == OP_LHU) ||
              (memOp_i == OP_SH);
    is_word = (memOp_i == OP_LW) || (memOp_i == OP_SW);
    is_st   = (memOp_i == OP_SB) || (memOp_i == OP_SH) ||
              (memOp_i == OP_SW);
    is_mem  = is_byte | is_half | is_word;
    misal   = (is_half & memAddr_i[0]) |
              (is_word & (|memAddr_i[1:0]));
    sel_c   = '0;
    wdata_c = '0;
    unique case (1'b1)
      is_byte: begin
        sel_c   = 4'b1000 >> memAddr_i[1:0];
        wdata_c = {4{storeData_i[7:0]}};
      end
      is_half: begin
        sel_c   = memAddr_i[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{storeData_i[15:0]}};
      end
      is_word: begin
        sel_c   = 4'b1111;
        wdata_c = storeData_i;
      end
      default: begin
        sel_c   = '0;
        wdata_c = '0;
      end
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    byte_c = '0;
    case (lo_q)
      2'd0: byte_c = memRdata_i[31:24];
      2'd1: byte_c = memRdata_i[23:16];
      2'd2: byte_c = memRdata_i[15:8];
      2'd3: byte_c = memRdata_i[7:0];
      default: byte_c = '0;
    endcase
    half_c = lo_q[1] ? memRdata_i[15:0] : memRdata_i[31:16];
    ld_c   = memRdata_i;
    case (op_q)
      OP_LB:   ld_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  ld_c = {24'd0, byte_c};
      OP_LH:   ld_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  ld_c = {16'd0, half_c};
      default: ld_c = memRdata_i;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (is_mem && !misal) state_n = WAIT;
      WAIT: if (memAck_i || tmo) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= '0;
      lo_q        <= '0;
      wreg_q      <= 1'b0;
      waddr_q     <= '0;
      memWe_o     <= 1'b0;
      memAddr_o   <= '0;
      memSel_o    <= '0;
      memWdata_o  <= '0;
      writeReg_o  <= 1'b0;
      writeAddr_o <= '0;
      writeData_o <= '0;
      excAddr_o   <= 1'b0;
      busErr_o    <= 1'b0;
    end else begin
      excAddr_o <= 1'b0;
      busErr_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            writeReg_o  <= writeReg_i;
            writeAddr_o <= writeAddr_i;
            writeData_o <= writeData_i;
          end else if (misal) begin
            excAddr_o  <= 1'b1;
            writeReg_o <= 1'b0;
          end else begin
            op_q       <= memOp_i;
            lo_q       <= memAddr_i[1:0];
            wreg_q     <= writeReg_i;
            waddr_q    <= writeAddr_i;
            memWe_o    <= is_st;
            memAddr_o  <= {memAddr_i[31:2], 2'b00};
            memSel_o   <= sel_c;
            memWdata_o <= wdata_c;
            writeReg_o <= 1'b0;
            cnt        <= '0;
          end
        end
        WAIT: begin
          if (memAck_i) begin
            cnt <= '0;
            if (ld_q) begin
              writeReg_o  <= wreg_q;
              writeAddr_o <= waddr_q;
              writeData_o <= ld_c;
            end else begin
              writeReg_o <= 1'b0;
            end
          end else if (tmo) begin
            cnt        <= '0;
            busErr_o   <= 1'b1;
            writeReg_o <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
